// File: rtl/spi_agg_pkg.sv
// Shared definitions for the SPI aggregator: frame-scheduler state
// encoding, default widths and the default watchdog limit.
package spi_agg_pkg;

    localparam int PERIOD_W_DEF = 16;
    localparam int BURST_W_DEF  = 8;
    localparam int FCNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF  = 4096;

    // Frame scheduler state encoding (fixed codes, legacy-compatible)
    typedef logic [2:0] sched_state_t;

    localparam sched_state_t S_IDLE  = 3'd0;
    localparam sched_state_t S_WAIT  = 3'd1;
    localparam sched_state_t S_START = 3'd2;
    localparam sched_state_t S_BUSY  = 3'd3;
    localparam sched_state_t S_DRAIN = 3'd4;

    // States in which the scheduler reports itself as active
    function automatic logic is_active(input sched_state_t s);
        return (s == S_WAIT) || (s == S_START) || (s == S_BUSY);
    endfunction

endpackage

// File: rtl/agg_period_timer.sv
// Free-running frame period timer. Counts 0..period and ticks on the
// last count; the period value is captured at each wrap so a change
// made mid-period only affects the following period.
module agg_period_timer
    import spi_agg_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] period_q;

    assign tick = run && (cnt_q == period_q);

    // Counter with wrap-time sampling of the period; clear re-arms from zero
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so rst_n is just the first branch
        // of a clocked block and is deliberately absent from the sensitivity list.
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else if (clear) begin
            cnt_q    <= '0;
            period_q <= period;
        end else if (run) begin
            if (cnt_q == period_q) begin
                cnt_q    <= '0;
                period_q <= period;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/agg_frame_scheduler.sv
// Frame sequencer for the SPI aggregator. Issues agg_start pulses from
// the period timer (timer mode) or from trigger edges as fixed-length
// bursts (trigger mode), counts completed frames, flags lost starts as
// overruns and stuck frames through a BUSY watchdog.
module agg_frame_scheduler
    import spi_agg_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int BURST_W  = BURST_W_DEF,
    parameter int FCNT_W   = FCNT_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic                trig,
    output logic                agg_start,
    input  logic                agg_done,
    output logic [FCNT_W-1:0]   frame_cnt,
    output logic                overrun,
    output logic                fault,
    input  logic                err_clr,
    output logic                active
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_t        state_q, state_d;
    logic [BURST_W-1:0]  burst_q, burst_d, burst_dec;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                trig_q;
    logic                trig_rise, tick, start_req, wd_exp;
    logic                ovr_set, flt_set, frame_inc;

    agg_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == S_IDLE),
        .run    (is_active(state_q)),
        .period (period),
        .tick   (tick)
    );

    assign trig_rise = trig && !trig_q;
    assign start_req = mode ? trig_rise : tick;
    assign wd_exp    = (wd_q == WD_W'(TIMEOUT - 1));
    assign burst_dec = (burst_q == '0) ? '0 : burst_q - 1'b1;

    // Next-state logic: FSM transitions, burst/watchdog counters, flag events
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        burst_d   = burst_q;
        wd_d      = '0;
        ovr_set   = 1'b0;
        flt_set   = 1'b0;
        frame_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                burst_d = '0;
                if (en) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (!mode && tick) begin
                    state_d = S_START;
                end else if (mode && trig_rise) begin
                    state_d = S_START;
                    burst_d = (burst_len == '0) ? BURST_W'(1) : burst_len;
                end
            end
            S_START: begin
                ovr_set = start_req;
                state_d = en ? S_BUSY : S_DRAIN;
            end
            S_BUSY: begin
                wd_d = wd_q + 1'b1;
                if (agg_done) begin
                    frame_inc = 1'b1;
                    burst_d   = burst_dec;
                    // A tick coinciding with done is accepted, a trigger edge is not
                    ovr_set   = mode && trig_rise;
                    if (!en)                          state_d = S_IDLE;
                    else if (mode && burst_dec != '0) state_d = S_START;
                    else if (!mode && tick)           state_d = S_START;
                    else                              state_d = S_WAIT;
                end else if (wd_exp) begin
                    flt_set = 1'b1;
                    ovr_set = start_req;
                    burst_d = '0;
                    state_d = en ? S_WAIT : S_IDLE;
                end else begin
                    ovr_set = start_req;
                    if (!en) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                wd_d = wd_q + 1'b1;
                if (agg_done) begin
                    frame_inc = 1'b1;
                    state_d   = S_IDLE;
                end else if (wd_exp) begin
                    flt_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs; err_clr wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            burst_q   <= '0;
            wd_q      <= '0;
            trig_q    <= 1'b0;
            agg_start <= 1'b0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            fault     <= 1'b0;
            active    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            burst_q   <= burst_d;
            wd_q      <= wd_d;
            trig_q    <= trig;
            agg_start <= (state_q == S_START);
            active    <= is_active(state_d);
            if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
            overrun   <= !err_clr && (overrun || ovr_set);
            fault     <= !err_clr && (fault || flt_set);
        end
    end

endmodule
